// File: rtl/core_pkg.sv
// Shared types and constants for the writeback stage and its load formatter.
package core_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_kind_t;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wb_state_t;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of an aligned memory word and extends it to 32 bits.
module load_align
    import core_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    input  word_t      i_rdata,
    output word_t      o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[8*i_addr_lo +: 8];
        // Half lane comes from addr_lo[1] only; misaligned halves never reach here.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            LOAD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LH:  o_data = {{16{w_half[15]}}, w_half};
            LOAD_LBU: o_data = {24'd0, w_byte};
            LOAD_LHU: o_data = {16'd0, w_half};
            default:  o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/wb_unit.sv
// Writeback stage: retires ALU results, waits for and formats load data, drives the
// register-file write port and mirrors it as a forwarding tap for decode.
module wb_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  ex_kind,
    input  reg_addr_t   ex_rd_addr,
    input  word_t       ex_result,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        mem_rvalid,
    input  word_t       mem_rdata,
    output logic        write_en,
    output reg_addr_t   rd_addr,
    output word_t       rd_data,
    output logic        fwd_valid,
    output reg_addr_t   fwd_addr,
    output word_t       fwd_data,
    output logic        load_fault
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    wb_state_t  r_state, w_state_nxt;
    logic       r_we, w_we_nxt;
    logic       r_fault, w_fault_nxt;
    reg_addr_t  r_rd_addr, w_rd_addr_nxt;
    word_t      r_rd_data, w_rd_data_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    reg_addr_t  r_ld_rd, w_ld_rd_nxt;
    logic [2:0] r_ld_f3, w_ld_f3_nxt;
    logic [1:0] r_ld_lo, w_ld_lo_nxt;
    word_t      w_aligned;

    load_align u_align (
        .i_funct3  (r_ld_f3),
        .i_addr_lo (r_ld_lo),
        .i_rdata   (mem_rdata),
        .o_data    (w_aligned)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_we_nxt      = 1'b0;
        w_fault_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_data_nxt = r_rd_data;
        w_cnt_nxt     = r_cnt;
        w_ld_rd_nxt   = r_ld_rd;
        w_ld_f3_nxt   = r_ld_f3;
        w_ld_lo_nxt   = r_ld_lo;
        case (r_state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (ex_kind == WB_ALU) begin
                        w_we_nxt      = (ex_rd_addr != '0);
                        w_rd_addr_nxt = ex_rd_addr;
                        w_rd_data_nxt = ex_result;
                    end else if (ex_kind == WB_LOAD) begin
                        w_ld_rd_nxt = ex_rd_addr;
                        w_ld_f3_nxt = ex_funct3;
                        w_ld_lo_nxt = ex_addr_lo;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT_LOAD;
                    end
                end
            end
            S_WAIT_LOAD: begin
                // Data arriving on the final counted cycle still wins over the timeout.
                if (mem_rvalid) begin
                    w_we_nxt      = (r_ld_rd != '0);
                    w_rd_addr_nxt = r_ld_rd;
                    w_rd_data_nxt = w_aligned;
                    w_state_nxt   = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_fault   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_cnt     <= '0;
            r_ld_rd   <= '0;
            r_ld_f3   <= '0;
            r_ld_lo   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_we      <= w_we_nxt;
            r_fault   <= w_fault_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ld_rd   <= w_ld_rd_nxt;
            r_ld_f3   <= w_ld_f3_nxt;
            r_ld_lo   <= w_ld_lo_nxt;
        end
    end

    assign ex_ready   = (r_state == S_IDLE);
    assign write_en   = r_we;
    assign rd_addr    = r_rd_addr;
    assign rd_data    = r_rd_data;
    assign load_fault = r_fault;
    // Register file reads are combinational, so decode needs this cycle's write value.
    assign fwd_valid  = r_we;
    assign fwd_addr   = r_rd_addr;
    assign fwd_data   = r_rd_data;
endmodule

// File: tb/tb_wb_unit.sv
// Directed plus randomized checks of wb_unit against a small behavioural model.
module tb_wb_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_kind;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        load_fault;

    int total = 0;
    int bad   = 0;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    wb_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_kind(ex_kind),
        .ex_rd_addr(ex_rd_addr), .ex_result(ex_result), .ex_funct3(ex_funct3),
        .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] w);
        longint b, h;
        b = (longint'(w) / (longint'(1) << (8 * lo))) % 256;
        h = (longint'(w) / (longint'(1) << (16 * (lo / 2)))) % 65536;
        case (f3)
            0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
            1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic we, input logic flt, input logic rdy);
        chk({tag, ".we"},    32'(write_en),   32'(we));
        chk({tag, ".fv"},    32'(fwd_valid),  32'(we));
        chk({tag, ".fault"}, 32'(load_fault), 32'(flt));
        chk({tag, ".ready"}, 32'(ex_ready),   32'(rdy));
        chk({tag, ".addr"},  32'(rd_addr),    32'(m_addr));
        chk({tag, ".data"},  rd_data,         m_data);
        chk({tag, ".faddr"}, 32'(fwd_addr),   32'(m_addr));
        chk({tag, ".fdata"}, fwd_data,        m_data);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_alu(input string tag, input int kind, input int rd, input logic [31:0] res);
        ex_valid = 1'b1; ex_kind = 2'(kind); ex_rd_addr = 5'(rd); ex_result = res;
        chk({tag, ".rdy_in"}, 32'(ex_ready), 32'd1);
        tick;
        ex_valid = 1'b0;
        if (kind == 1) begin
            m_addr = 5'(rd);
            m_data = res;
        end
        outs(tag, (kind == 1) && (rd != 0), 1'b0, 1'b1);
        tick;
        outs({tag, ".after"}, 1'b0, 1'b0, 1'b1);
    endtask

    // d = idle wait cycles before rvalid; d >= T means the data never comes.
    task automatic do_load(input string tag, input int rd, input int f3, input int lo,
                           input logic [31:0] w, input int d);
        ex_valid = 1'b1; ex_kind = 2'd2; ex_rd_addr = 5'(rd);
        ex_funct3 = 3'(f3); ex_addr_lo = 2'(lo);
        tick;
        ex_valid = 1'b0; ex_funct3 = 3'($urandom); ex_addr_lo = 2'($urandom);
        outs({tag, ".acc"}, 1'b0, 1'b0, 1'b0);
        if (d < T) begin
            for (int i = 0; i < d; i++) begin
                tick;
                outs({tag, ".wait"}, 1'b0, 1'b0, 1'b0);
            end
            mem_rvalid = 1'b1; mem_rdata = w;
            tick;
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            m_addr = 5'(rd);
            m_data = ref_load(f3, lo, w);
            outs({tag, ".wr"}, rd != 0, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < T - 1; i++) begin
                tick;
                outs({tag, ".wait"}, 1'b0, 1'b0, 1'b0);
            end
            tick;
            outs({tag, ".to"}, 1'b0, 1'b1, 1'b1);
        end
        tick;
        outs({tag, ".after"}, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int f3s[7] = '{0, 1, 2, 4, 5, 3, 7};
        rst = 1'b1; ex_valid = 1'b0; ex_kind = 2'd0; ex_rd_addr = '0; ex_result = '0;
        ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        m_addr = '0; m_data = '0;
        tick; tick;
        rst = 1'b0;
        outs("reset", 1'b0, 1'b0, 1'b1);

        do_alu("alu", 1, 5, 32'hDEADBEEF);
        do_alu("x0", 1, 0, 32'h0000_1234);
        do_alu("none", 0, 9, 32'h5555_AAAA);
        do_load("lb", 7, 0, 3, 32'h80FF_0000, 3);
        do_load("lhu", 8, 5, 2, 32'h8001_1234, 0);
        do_load("lh", 9, 1, 2, 32'h8001_1234, 1);
        do_load("lw", 10, 2, 0, 32'h8001_1234, 2);
        do_load("lbu", 11, 4, 1, 32'h0000_9A00, 0);
        do_load("timeout", 12, 2, 0, 32'h1111_2222, T);
        do_load("lastcyc", 13, 2, 0, 32'h3333_4444, T - 1);
        do_load("ld_x0", 0, 2, 0, 32'h7777_8888, 1);

        // Stray rvalid while idle must be ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        mem_rvalid = 1'b0;
        outs("idle_rv", 1'b0, 1'b0, 1'b1);

        // Reset while waiting drops the load; a late rvalid must not write.
        ex_valid = 1'b1; ex_kind = 2'd2; ex_rd_addr = 5'd14; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
        tick;
        ex_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_addr = '0; m_data = '0;
        outs("rst_mid", 1'b0, 1'b0, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick;
        mem_rvalid = 1'b0;
        outs("rst_late_rv", 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(0, 2));
            if (k == 2)
                do_load("rnd_ld", int'($urandom_range(0, 31)), f3s[$urandom_range(0, 6)],
                        int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, T + 1)));
            else
                do_alu("rnd_alu", k, int'($urandom_range(0, 31)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
